// File: rtl/decode_arb_pkg.sv
// Shared types and constants for the two-source decode stream arbiter.
// Pure declarations: no latency, no flow control.
package decode_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef logic src_id_t;

  localparam int NUM_SRC       = 2;
  localparam int TAG_DEPTH_DEF = 4;

  // Round-robin pick: rr_ptr breaks ties, a lone valid source always wins.
  function automatic src_id_t rr_pick(input logic v0, input logic v1, input src_id_t ptr);
    if (v0 && v1) return ptr;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/tag_fifo.sv
// Owner-ID FIFO recording grant order for the output demux; 1-cycle push-to-visible.
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps the count.
module tag_fifo
  import decode_arb_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  src_id_t push_dat,
  input  logic    pop,
  output src_id_t pop_dat,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  src_id_t       mem [DEPTH];

  logic push_ok;
  logic pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/decode_stream_arbiter.sv
// Per-packet round-robin arbiter sharing one ZFP decode pipeline between two encoded-bit streams.
// Grant costs 1 IDLE cycle, flits pass through in 0 cycles; m_ready goes straight to the owning source.
module decode_stream_arbiter
  import decode_arb_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s0_data_tdata,
  input  logic              s0_data_tlast,
  input  logic              s0_valid,
  output logic              s0_ready,
  input  logic [DATA_W-1:0] s1_data_tdata,
  input  logic              s1_data_tlast,
  input  logic              s1_valid,
  output logic              s1_ready,
  output logic [DATA_W-1:0] m_data_tdata,
  output logic              m_data_tlast,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              tag_id,
  output logic              tag_valid,
  input  logic              tag_ready,
  output logic [CNT_W-1:0]  pkt_cnt0,
  output logic [CNT_W-1:0]  pkt_cnt1
);

  state_t  state, state_nxt;
  src_id_t sel, sel_nxt;
  src_id_t rr_ptr, rr_nxt;
  src_id_t winner;
  src_id_t tag_head;

  logic grant;
  logic pkt_done;
  logic tag_full;
  logic tag_empty;

  logic [CNT_W-1:0] pkt_cnt [NUM_SRC];

  // Full is judged on the registered count, so a same-cycle pop never lets a grant through.
  assign grant    = (state == IDLE) && (s0_valid || s1_valid) && !tag_full;
  assign winner   = rr_pick(s0_valid, s1_valid, rr_ptr);
  assign pkt_done = m_valid && m_ready && m_data_tlast;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = BUSY;
          sel_nxt   = winner;
        end
      end
      BUSY: begin
        if (pkt_done) begin
          state_nxt = IDLE;
          rr_nxt    = ~sel;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A source dropping valid mid-packet keeps the grant; m_valid simply follows it.
  always_comb begin
    m_data_tdata = '0;
    m_data_tlast = 1'b0;
    m_valid      = 1'b0;
    s0_ready     = 1'b0;
    s1_ready     = 1'b0;
    if (state == BUSY) begin
      if (sel == 1'b1) begin
        m_data_tdata = s1_data_tdata;
        m_data_tlast = s1_data_tlast;
        m_valid      = s1_valid;
        s1_ready     = m_ready;
      end else begin
        m_data_tdata = s0_data_tdata;
        m_data_tlast = s0_data_tlast;
        m_valid      = s0_valid;
        s0_ready     = m_ready;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) pkt_cnt[i] <= '0;
    end else if (pkt_done) begin
      pkt_cnt[sel] <= pkt_cnt[sel] + CNT_W'(1);
    end
  end

  assign pkt_cnt0 = pkt_cnt[0];
  assign pkt_cnt1 = pkt_cnt[1];

  tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (grant),
    .push_dat (winner),
    .pop      (tag_ready),
    .pop_dat  (tag_head),
    .full     (tag_full),
    .empty    (tag_empty)
  );

  assign tag_id    = tag_head;
  assign tag_valid = !tag_empty;

endmodule

// File: doc/decode_stream_arbiter.md
Name: decode_stream_arbiter

Overview:
- Shares one ZFP decode pipeline (64-bit encoded-bits input, tdata/tlast valid/ready) between two encoded-bit-stream requesters.
- Arbitration is per packet: once a source is granted, the grant is held until its tlast flit is accepted downstream.
- Each grant pushes the owner ID into a tag FIFO. The output-side demux pops that FIFO to route the decoded fp stream back to the right consumer.
- Sits between the stream drivers and the decoder input, in the same clock domain.

Parameters:
- DATA_W, 64, encoded-bits flit width.
- TAG_DEPTH, 4, tag FIFO entries; power of 2, at least 2.
- CNT_W, 16, width of the per-source packet counters.

Ports:
- clk  in  1  design clock; all state on the rising edge.
- reset  in  1  asynchronous active-low reset.
- s0_data_tdata  in  DATA_W  source 0 flit.
- s0_data_tlast  in  1  source 0 last flit of packet.
- s0_valid  in  1  source 0 flit valid.
- s0_ready  out  1  source 0 flit accepted.
- s1_data_tdata, s1_data_tlast, s1_valid, s1_ready  same as source 0, for source 1.
- m_data_tdata  out  DATA_W  flit to decoder.
- m_data_tlast  out  1  last flit to decoder.
- m_valid  out  1  flit to decoder valid.
- m_ready  in  1  decoder ready.
- tag_id  out  1  owner of the oldest granted packet.
- tag_valid  out  1  tag FIFO not empty.
- tag_ready  in  1  pop request from the output demux.
- pkt_cnt0  out  CNT_W  packets completed from source 0.
- pkt_cnt1  out  CNT_W  packets completed from source 1.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, sel=0, rr_ptr=0.
  - Tag FIFO emptied.
  - pkt_cnt0=pkt_cnt1=0.
  - s0_ready, s1_ready, m_valid and tag_valid are all 0.
- Reset mid-packet:
  - The packet in flight is dropped without further handshakes.
  - No tag or count is retained.
  - After deassertion, arbitration restarts from IDLE.
- FSM state IDLE:
  - Outputs: m_valid=0, s0_ready=0, s1_ready=0.
  - Grant condition: at least one sX_valid=1 AND tag_count<TAG_DEPTH (registered count).
  - Winner selection is round-robin. If both sources are valid, the winner is rr_ptr; otherwise the single valid source wins.
  - On grant: sel<=winner, push winner into the tag FIFO, state<=BUSY.
- FSM state BUSY (pure combinational pass-through of the selected source):
  - m_data_tdata, m_data_tlast and m_valid come from source sel.
  - s[sel]_ready = m_ready; the other source's ready = 0.
  - On handshake (m_valid & m_ready) with tlast=1: state<=IDLE, rr_ptr<=~sel, pkt_cnt[sel]<=pkt_cnt[sel]+1 (wraps mod 2^CNT_W).
  - A handshake with tlast=0 stays in BUSY.
- Latency:
  - Grant decision: 1 cycle (one IDLE cycle between consecutive packets).
  - Flit path in BUSY: 0 cycles.
- Back-pressure:
  - The decoder may deassert m_ready at any time; data is held by the source.
  - A source dropping valid mid-packet is legal. The grant is held, with m_valid=0, until tlast is accepted.
- Tag FIFO:
  - Push occurs only on grant. Pop occurs on tag_valid & tag_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Full: no grant is issued; sources wait in IDLE. A pop in the same cycle does not bypass — the grant happens the next cycle.
  - Empty: tag_valid=0, pop ignored.
  - Pointers wrap mod TAG_DEPTH.
- Single-flit packet (tlast on the first flit): BUSY lasts exactly one handshake cycle.

Decomposition:
- Shared package decode_arb_pkg holds:
  - state enum {IDLE, BUSY};
  - typedef src_id_t (1 bit);
  - constants NUM_SRC=2 and default TAG_DEPTH.
- Sub-module tag_fifo (synchronous FIFO; async active-low reset; push/pop/full/empty/count).

Test Plan:
- Reset then idle: reset=0 for 5 cycles, then 1, no valids -> all readies=0, m_valid=0, tag_valid=0, counters=0.
- Single source: s0 sends a 3-flit packet (tdata 0x1,0x2,0x3; last on 0x3), m_ready=1 -> m_data sequence 0x1,0x2,0x3 with tlast on the third flit; tag_id=0 pushed; pkt_cnt0=1.
- Contention: s0 and s1 both continuously offer 2-flit packets, m_ready=1 -> packets alternate 0,1,0,1; tag FIFO holds 0,1,0,1; one idle cycle between packets.
- Tag full: tag_ready=0, 4 single-flit packets granted -> 5th request stalls in IDLE; tag_ready=1 for 1 cycle -> grant on the following cycle, tag_id pops 0 first.
- Back-pressure / valid gap: in BUSY, m_ready=0 for 3 cycles, then s1_valid=0 for 2 cycles mid-packet -> no flit lost or duplicated, s0_ready stays 0, grant held until tlast.
- Reset mid-packet: assert reset after flit 2 of 4 -> outputs zero immediately (asynchronously); after release, s1 is granted first if only s1 is valid; pkt_cnt0 and pkt_cnt1 are 0.
